// File: rtl/xif_copro_pkg.sv
// Shared types and constants for the XIF coprocessor.
// commit_state_e : per-ID commit-tracking state (2-bit encoding).
// X_ID_WIDTH     : XIF instruction ID width shared across the coprocessor.
package xif_copro_pkg;

    localparam int unsigned X_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        CS_FREE      = 2'b00,
        CS_PENDING   = 2'b01,
        CS_COMMITTED = 2'b10,
        CS_KILLED    = 2'b11
    } commit_state_e;

    // Resolved state for a commit decision.
    function automatic commit_state_e commit_result(input logic kill);
        return kill ? CS_KILLED : CS_COMMITTED;
    endfunction

endpackage

// File: rtl/xif_copro_commit_buffer.sv
// Per-ID commit-state tracker between the XIF commit interface and the
// coprocessor controller. Records accepted offloads, captures commit/kill,
// and reports whether the input-buffer head may execute or must be dropped.
//
// Ports:
//   clk_i, rst_ni                       clock, synchronous active-low reset
//   alloc_valid_i, alloc_id_i           accepted issue handshake
//   alloc_ready_o                       entry for alloc_id_i is free (or freed now)
//   commit_valid_i, commit_id_i,
//   commit_kill_i                       XIF commit handshake
//   head_valid_i, head_id_i             input-buffer head
//   head_committed_o, head_killed_o     head decision (includes commit bypass)
//   consume_i                           head popped; frees head_id_i
//   outstanding_o                       number of non-FREE entries
//   err_o                               sticky protocol error
module xif_copro_commit_buffer
    import xif_copro_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH = xif_copro_pkg::X_ID_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alloc_valid_i,
    input  logic [X_ID_WIDTH-1:0] alloc_id_i,
    output logic                  alloc_ready_o,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    input  logic                  head_valid_i,
    input  logic [X_ID_WIDTH-1:0] head_id_i,
    output logic                  head_committed_o,
    output logic                  head_killed_o,
    input  logic                  consume_i,
    output logic [X_ID_WIDTH:0]   outstanding_o,
    output logic                  err_o
);

    localparam int unsigned NUM_ENTRIES = 2 ** X_ID_WIDTH;
    localparam int unsigned CNT_W       = X_ID_WIDTH + 1;

    commit_state_e    state_q [NUM_ENTRIES];
    commit_state_e    state_d [NUM_ENTRIES];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    commit_state_e head_state, alloc_state, commit_state;
    logic          head_hit, alloc_fire, alloc_commit;
    logic          commit_err, alloc_err, consume_err;
    logic          cnt_inc, cnt_dec;

    // Lookups and head decision (commit is bypassed into the head in the same cycle).
    always_comb begin
        head_state   = state_q[head_id_i];
        alloc_state  = state_q[alloc_id_i];
        commit_state = state_q[commit_id_i];
        head_hit     = commit_valid_i & (commit_id_i == head_id_i);

        head_committed_o = head_valid_i &
                           ((head_state == CS_COMMITTED) |
                            ((head_state == CS_PENDING) & head_hit & ~commit_kill_i));
        head_killed_o    = head_valid_i &
                           ((head_state == CS_KILLED) |
                            ((head_state == CS_PENDING) & head_hit & commit_kill_i));

        // An entry being consumed this cycle can be re-allocated immediately.
        alloc_ready_o = (alloc_state == CS_FREE) | (consume_i & (head_id_i == alloc_id_i));
        alloc_fire    = alloc_valid_i & alloc_ready_o;
        alloc_commit  = alloc_fire & commit_valid_i & (commit_id_i == alloc_id_i);

        alloc_err   = alloc_valid_i & ~alloc_ready_o;
        // A commit that lands together with its own alloc targets the new instance.
        commit_err  = commit_valid_i & ~alloc_commit &
                      ((commit_state == CS_COMMITTED) | (commit_state == CS_KILLED));
        consume_err = consume_i & ~head_committed_o & ~head_killed_o;

        cnt_inc = alloc_fire;
        cnt_dec = consume_i & (head_state != CS_FREE);
    end

    // Entry next state: commit, then consume, then alloc (alloc wins over consume).
    always_comb begin
        state_d = state_q;
        if (commit_valid_i && (commit_state == CS_PENDING)) begin
            state_d[commit_id_i] = commit_result(commit_kill_i);
        end
        if (consume_i) begin
            state_d[head_id_i] = CS_FREE;
        end
        if (alloc_fire) begin
            state_d[alloc_id_i] = alloc_commit ? commit_result(commit_kill_i) : CS_PENDING;
        end
    end

    // Outstanding counter, saturating at both ends.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec && (cnt_q != CNT_W'(NUM_ENTRIES))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_dec && !cnt_inc && (cnt_q != CNT_W'(0))) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        err_d = err_q | alloc_err | commit_err | consume_err;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= CS_FREE;
            end
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

endmodule
